// File: rtl/warp_ibuffer_pkg.sv
// warp_ibuffer_pkg
//   Shared definitions for the per-warp instruction buffer: default sizing,
//   derived widths, the per-warp status struct and a clog2 helper that never
//   returns 0 (so a single-warp build still has a 1-bit warp id).
package warp_ibuffer_pkg;

  localparam int IBUF_DEPTH     = 4;
  localparam int IBUF_NUM_WARPS = 4;
  localparam int IBUF_DATAW     = 64;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int WID_W = clog2_min1(IBUF_NUM_WARPS);
  localparam int CNT_W = $clog2(IBUF_DEPTH + 1);

  typedef struct packed {
    logic full;
    logic empty;
  } warp_status_t;

endpackage

// File: rtl/warp_ibuffer_if.sv
// warp_ibuffer_if
//   Bundles the decode-side push port, the per-warp output lanes, the flush
//   request and the scheduler status flags of warp_ibuffer.
//   slave  : the instruction buffer itself.
//   master : decode / consumer / scheduler side.
//   Signals:
//     dec_valid, dec_wid, dec_data -> push request; dec_ready <- accepted
//     flush_mask                   -> per-warp synchronous flush
//     ibuf_valid, ibuf_data        <- per-warp head entry; ibuf_ready -> take
//     warp_full, warp_empty        <- per-warp occupancy status
interface warp_ibuffer_if
  import warp_ibuffer_pkg::*;
#(
  parameter int NUM_WARPS = IBUF_NUM_WARPS,
  parameter int DATAW     = IBUF_DATAW
);
  localparam int WW = clog2_min1(NUM_WARPS);

  logic                       dec_valid;
  logic [WW-1:0]              dec_wid;
  logic [DATAW-1:0]           dec_data;
  logic                       dec_ready;
  logic [NUM_WARPS-1:0]       flush_mask;
  logic [NUM_WARPS-1:0]       ibuf_valid;
  logic [NUM_WARPS*DATAW-1:0] ibuf_data;
  logic [NUM_WARPS-1:0]       ibuf_ready;
  logic [NUM_WARPS-1:0]       warp_full;
  logic [NUM_WARPS-1:0]       warp_empty;

  modport slave (
    input  dec_valid, dec_wid, dec_data, flush_mask, ibuf_ready,
    output dec_ready, ibuf_valid, ibuf_data, warp_full, warp_empty
  );

  modport master (
    output dec_valid, dec_wid, dec_data, flush_mask, ibuf_ready,
    input  dec_ready, ibuf_valid, ibuf_data, warp_full, warp_empty
  );

endinterface

// File: rtl/warp_ibuffer_fifo.sv
// warp_ibuffer_fifo
//   Single-warp FIFO with push, pop and synchronous flush.
//   Ports:
//     clk, reset (active-low, synchronous)
//     flush      - clears pointers and count next cycle; blocks push and pop
//     push/push_data - write request (ignored when full)
//     pop        - advance head (ignored when empty)
//     head_data  - oldest entry, read combinationally from rd_ptr
//     full/empty - compares on the registered count
module warp_ibuffer_fifo
  import warp_ibuffer_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH,
  parameter int DATAW = IBUF_DATAW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [DATAW-1:0] push_data,
  input  logic             pop,
  output logic [DATAW-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  logic [DATAW-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             do_push, do_pop;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

  // Flush wins over both directions: a pop of a flushed warp is dropped and
  // a push to it is refused.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by plain overflow.
      if (do_push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign head_data = mem[rd_ptr_reg];

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge clk) disable iff (!reset)
    count_reg <= CW'(DEPTH));
`endif

endmodule

// File: rtl/warp_ibuffer.sv
// warp_ibuffer
//   Per-warp instruction buffer between decode and scoreboard staging.
//   One decoded instruction per cycle is steered by dec_wid into that warp's
//   private FIFO; each warp presents its oldest entry on its own valid/ready
//   lane, and reports full/empty to the scheduler. flush_mask empties warps.
//   Ports:
//     clk   - clock
//     reset - synchronous active-low reset
//     bus   - warp_ibuffer_if.slave (push port, output lanes, flush, status)
//   Build option:
//     IBUF_BYPASS_EN - when defined, an instruction for an empty, unflushed
//     warp is shown on that warp's lane in the same cycle; if taken at once
//     it never enters the FIFO. Undefined: 1-cycle minimum latency and no
//     combinational path from dec_* to ibuf_*.
module warp_ibuffer
  import warp_ibuffer_pkg::*;
#(
  parameter int NUM_WARPS = IBUF_NUM_WARPS,
  parameter int DEPTH     = IBUF_DEPTH,
  parameter int DATAW     = IBUF_DATAW
) (
  input  logic           clk,
  input  logic           reset,
  warp_ibuffer_if.slave  bus
);

  localparam int WW = clog2_min1(NUM_WARPS);

  warp_status_t         status [NUM_WARPS];
  logic [DATAW-1:0]     head_data [NUM_WARPS];
  logic [NUM_WARPS-1:0] wid_sel;
  logic [NUM_WARPS-1:0] full_vec;
  logic [NUM_WARPS-1:0] push_req;
  logic [NUM_WARPS-1:0] pop_req;
  logic                 dec_fire;

  // Readiness looks only at registered state, never at this cycle's pops.
  // Ids that select no warp (non power-of-two NUM_WARPS) are never accepted.
  assign bus.dec_ready = reset & |(wid_sel & ~full_vec & ~bus.flush_mask);
  assign dec_fire      = bus.dec_valid & bus.dec_ready;

  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
    assign wid_sel[gi]  = (bus.dec_wid == WW'(gi));
    assign full_vec[gi] = status[gi].full;

    warp_ibuffer_fifo #(
      .DEPTH (DEPTH),
      .DATAW (DATAW)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (bus.flush_mask[gi]),
      .push      (push_req[gi]),
      .push_data (bus.dec_data),
      .pop       (pop_req[gi]),
      .head_data (head_data[gi]),
      .full      (status[gi].full),
      .empty     (status[gi].empty)
    );

    assign bus.warp_full[gi]  = status[gi].full;
    assign bus.warp_empty[gi] = status[gi].empty;
    assign pop_req[gi]        = bus.ibuf_ready[gi] & ~status[gi].empty;

`ifdef IBUF_BYPASS_EN
    logic byp_hit;
    logic byp_take;

    assign byp_hit  = reset & bus.dec_valid & wid_sel[gi] & status[gi].empty
                    & ~bus.flush_mask[gi];
    // A bypassed instruction taken this cycle leaves the FIFO untouched.
    assign byp_take = byp_hit & bus.ibuf_ready[gi];

    assign bus.ibuf_valid[gi] = ~status[gi].empty | byp_hit;
    assign bus.ibuf_data[gi*DATAW +: DATAW] =
      status[gi].empty ? bus.dec_data : head_data[gi];
    assign push_req[gi] = dec_fire & wid_sel[gi] & ~byp_take;
`else
    assign bus.ibuf_valid[gi] = ~status[gi].empty;
    assign bus.ibuf_data[gi*DATAW +: DATAW] = head_data[gi];
    assign push_req[gi] = dec_fire & wid_sel[gi];
`endif

`ifndef SYNTHESIS
    // Consumers only raise ready on a lane that is actually presenting data.
    a_ready_needs_valid: assert property (@(posedge clk) disable iff (!reset)
      bus.ibuf_ready[gi] |-> bus.ibuf_valid[gi]);
`endif
  end

endmodule

// File: tb/tb_warp_ibuffer.sv
`timescale 1ns/1ps
module tb_warp_ibuffer;
  import warp_ibuffer_pkg::*;

  localparam int NW = 4;
  localparam int DP = 4;
  localparam int DW = 64;
`ifdef IBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  warp_ibuffer_if #(.NUM_WARPS(NW), .DATAW(DW)) bus ();

  // Consumer only asks for a lane that is presenting data.
  logic [NW-1:0] rdy_en = '0;
  assign bus.ibuf_ready = rdy_en & bus.ibuf_valid;

  warp_ibuffer #(.NUM_WARPS(NW), .DEPTH(DP), .DATAW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q [NW][$];
  int mcount [NW] = '{default: 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every transfer on an output lane is checked against the
  // scoreboard queue of that warp.
  initial begin : monitor
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int w = 0; w < NW; w++) begin
          if (bus.ibuf_valid[w] && bus.ibuf_ready[w]) begin
            if (exp_q[w].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL pop_w%0d: got %h expected no entry", w, bus.ibuf_data[w*DW +: DW]);
            end else begin
              e = exp_q[w].pop_front();
              check($sformatf("pop_w%0d", w), bus.ibuf_data[w*DW +: DW], e);
            end
          end
        end
      end
    end
  end

  // One clock cycle of stimulus. Expected push acceptance, lane valid and
  // status flags come from the bench's own occupancy model.
  task automatic step(input logic v, input int wid, input logic [DW-1:0] d,
                      input logic [NW-1:0] fl, input logic [NW-1:0] re, input string tag);
    logic exp_rdy;
    logic byp_take;
    logic pop_w, push_w;
    logic [NW-1:0] ev, ef, ee;
    bus.dec_valid  = v;
    bus.dec_wid    = 2'(wid);
    bus.dec_data   = d;
    bus.flush_mask = fl;
    rdy_en         = re;
    exp_rdy  = reset && (mcount[wid] < DP) && !fl[wid];
    byp_take = 1'b0;
    if (v && exp_rdy) begin
      if (BYP && mcount[wid] == 0 && re[wid]) byp_take = 1'b1;
      exp_q[wid].push_back(d);
    end
    @(negedge clk);
    check({tag, "_dec_ready"}, 64'(bus.dec_ready), 64'(exp_rdy));
    if (reset) begin
      for (int w = 0; w < NW; w++) begin
        ev[w] = (mcount[w] != 0) || (BYP && v && wid == w && mcount[w] == 0 && !fl[w]);
        ef[w] = (mcount[w] == DP);
        ee[w] = (mcount[w] == 0);
      end
      check({tag, "_ibuf_valid"}, 64'(bus.ibuf_valid), 64'(ev));
      check({tag, "_warp_full"}, 64'(bus.warp_full), 64'(ef));
      check({tag, "_warp_empty"}, 64'(bus.warp_empty), 64'(ee));
    end
    #1;
    for (int w = 0; w < NW; w++) begin
      if (!reset || fl[w]) begin
        mcount[w] = 0;
        exp_q[w].delete();
      end else begin
        pop_w  = re[w] && (mcount[w] != 0);
        push_w = v && exp_rdy && (wid == w) && !byp_take;
        mcount[w] = mcount[w] + int'(push_w) - int'(pop_w);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.dec_valid  = 1'b0;
    bus.dec_wid    = '0;
    bus.dec_data   = '0;
    bus.flush_mask = '0;

    // Reset: decode must be refused while reset is held.
    reset = 1'b0;
    repeat (3) step(1'b1, 0, 64'h99, 4'b0000, 4'b0000, "rst");
    reset = 1'b1;
    step(1'b0, 0, 64'h0, 4'b0000, 4'b0000, "idle");

    // First push visible the following cycle.
    step(1'b1, 2, 64'hA1, 4'b0000, 4'b0000, "t1_push");
    check("t1_valid_next", 64'(bus.ibuf_valid), 64'h4);
    check("t1_data_next", bus.ibuf_data[2*DW +: DW], 64'hA1);
    step(1'b0, 0, 64'h0, 4'b0000, 4'b0100, "t1_pop");

    // Fill wid 1, refuse a fifth, wid 0 still accepted, then in-order pops.
    for (int i = 0; i < 4; i++) step(1'b1, 1, 64'h10 + 64'(i), 4'b0000, 4'b0000, "t2_fill");
    check("t2_full1", 64'(bus.warp_full[1]), 64'h1);
    step(1'b1, 1, 64'h14, 4'b0000, 4'b0000, "t2_refused");
    step(1'b1, 0, 64'h20, 4'b0000, 4'b0000, "t2_w0");
    for (int i = 0; i < 4; i++) step(1'b0, 0, 64'h0, 4'b0000, 4'b0011, "t2_pop");

    // Full wid 3: a pop does not free space for a same-cycle push.
    for (int i = 0; i < 4; i++) step(1'b1, 3, 64'h30 + 64'(i), 4'b0000, 4'b0000, "t3_fill");
    step(1'b1, 3, 64'h34, 4'b0000, 4'b1000, "t3_pushpop");
    step(1'b1, 3, 64'h35, 4'b0000, 4'b0000, "t3_refill");
    check("t3_full3", 64'(bus.warp_full[3]), 64'h1);

    // Wrap-around on wid 0 with occupancy held at 2.
    step(1'b1, 0, 64'h40, 4'b0000, 4'b0000, "t4_pre");
    step(1'b1, 0, 64'h41, 4'b0000, 4'b0000, "t4_pre");
    for (int i = 0; i < 10; i++) step(1'b1, 0, 64'h42 + 64'(i), 4'b0000, 4'b0001, "t4_wrap");

    // Flush wid 1 while pushing to wid 1 (refused) and then wid 0 (accepted).
    for (int i = 0; i < 3; i++) step(1'b1, 1, 64'h50 + 64'(i), 4'b0000, 4'b0000, "t5_fill");
    step(1'b1, 1, 64'h53, 4'b0010, 4'b0000, "t5_flush_w1");
    step(1'b1, 0, 64'h60, 4'b0010, 4'b0000, "t5_flush_w0");
    check("t5_empty1", 64'(bus.warp_empty[1]), 64'h1);
    check("t5_empty0", 64'(bus.warp_empty[0]), 64'h0);

    // Empty wid 2 with the consumer ready.
    step(1'b1, 2, 64'h55, 4'b0000, 4'b0100, "t6_byp");
    check("t6_empty2", 64'(bus.warp_empty[2]), 64'(BYP));
    step(1'b0, 0, 64'h0, 4'b0000, 4'b0100, "t6_after");

    // Drain everything and confirm nothing was lost.
    repeat (8) step(1'b0, 0, 64'h0, 4'b0000, 4'b1111, "drain");
    for (int w = 0; w < NW; w++) check($sformatf("left_w%0d", w), 64'(exp_q[w].size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
